// File: rtl/ssm_norm_pkg.sv
// Shared types and constants for the segmented multiplier product normalizer.
// Optional round-to-nearest-even is selected with SSM_NORM_RNE_EN.
package ssm_norm_pkg;
    localparam int PROD_W = 26;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;
    localparam int POS_W  = $clog2(PROD_W);
    localparam int ERAW_W = EXP_W + 2;

    localparam logic signed [ERAW_W-1:0] E_MAX = ERAW_W'((1 << EXP_W) - 1);
    localparam logic signed [ERAW_W-1:0] E_MIN = ERAW_W'(1);

    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF
    } cls_t;

    typedef struct packed {
        logic                     sign;
        cls_t                     cls;
        logic signed [ERAW_W-1:0] eraw;
        logic [PROD_W-2:0]        aligned;
    } s1_t;
endpackage

// File: rtl/ssm_lod.sv
// Combinational leading-one detector: position of the highest set bit.
// Reused by the divider back end, so width is a parameter.
module ssm_lod
    import ssm_norm_pkg::*;
#(
    parameter int W  = PROD_W,
    parameter int PW = $clog2(W)
) (
    input  logic [W-1:0]  din,
    output logic [PW-1:0] pos,
    output logic          zero
);
    always_comb begin
        pos  = '0;
        zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                pos  = i[PW-1:0];
                zero = 1'b0;
            end
        end
    end
endmodule

// File: rtl/ssm_prod_normalizer.sv
// Two-stage normalize/round back end producing binary32 from a fixed-point product.
// SSM_NORM_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module ssm_prod_normalizer
    import ssm_norm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic [EXP_W-1:0]  exp_a,
    input  logic [EXP_W-1:0]  exp_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_ovf,
    output logic              out_unf
);
    logic              s1_valid;
    logic              s1_adv;
    s1_t               s1;
    s1_t               s1_d;
    logic [POS_W-1:0]  lead;
    logic              prod_zero;
    logic [POS_W-1:0]  shamt;
    logic [PROD_W-1:0] shifted;
    logic              unused_lead;

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    ssm_lod #(.W(PROD_W), .PW(POS_W)) u_lod (
        .din  (prod),
        .pos  (lead),
        .zero (prod_zero)
    );

    assign shamt       = POS_W'(PROD_W - 1) - lead;
    assign shifted     = prod << shamt;
    assign unused_lead = shifted[PROD_W-1];

    always_comb begin
        s1_d.sign    = sign_a ^ sign_b;
        s1_d.aligned = shifted[PROD_W-2:0];
        s1_d.eraw    = ERAW_W'(exp_a) + ERAW_W'(exp_b) + ERAW_W'(lead)
                     - ERAW_W'(BIAS + PROD_W - 2);
        if (prod_zero || exp_a == '0 || exp_b == '0)
            s1_d.cls = CLS_ZERO;
        else if (&exp_a || &exp_b)
            s1_d.cls = CLS_INF;
        else
            s1_d.cls = CLS_NORM;
    end

    logic [MAN_W-1:0]         man;
    logic [MAN_W-1:0]         man_r;
    logic signed [ERAW_W-1:0] eraw_r;
    logic [31:0]              res;
    logic                     ovf;
    logic                     unf;

    assign man = s1.aligned[PROD_W-2 -: MAN_W];

`ifdef SSM_NORM_RNE_EN
    logic guard;
    logic sticky;
    logic rnd;
    logic carry;

    assign guard  = s1.aligned[PROD_W-2-MAN_W];
    assign sticky = |s1.aligned[PROD_W-3-MAN_W:0];
    assign rnd    = guard && (sticky || man[0]);
    assign {carry, man_r} = {1'b0, man} + (MAN_W+1)'(rnd);
    assign eraw_r = s1.eraw + ERAW_W'(carry);
`else
    logic unused_tail;

    assign man_r       = man;
    assign eraw_r      = s1.eraw;
    assign unused_tail = ^s1.aligned[PROD_W-2-MAN_W:0];
`endif

    // Overflow is tested first so it wins over underflow.
    always_comb begin
        res = {s1.sign, eraw_r[EXP_W-1:0], man_r};
        ovf = 1'b0;
        unf = 1'b0;
        case (s1.cls)
            CLS_ZERO: res = {s1.sign, {(EXP_W+MAN_W){1'b0}}};
            CLS_INF:  res = {s1.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            default: begin
                if (eraw_r >= E_MAX) begin
                    res = {s1.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf = 1'b1;
                end else if (eraw_r < E_MIN) begin
                    res = {s1.sign, {(EXP_W+MAN_W){1'b0}}};
                    unf = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else begin
            if (in_ready)
                s1_valid <= in_valid;
            if (in_valid && in_ready)
                s1 <= s1_d;
            if (s1_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= res;
                    out_ovf  <= ovf;
                    out_unf  <= unf;
                end
            end
        end
    end
endmodule

// File: tb/tb_ssm_prod_normalizer.sv
// Scoreboard bench: directed products with hand-computed binary32 results.
// Expected rounding results follow SSM_NORM_RNE_EN.
module tb_ssm_prod_normalizer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] prod;
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_unf;

    always #5 clk = ~clk;

    ssm_prod_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .exp_a     (exp_a),
        .exp_b     (exp_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    logic [33:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [25:0] ONE = 26'h1000000;

`ifdef SSM_NORM_RNE_EN
    localparam logic [31:0] RND_UP = 32'h3F800002;
    localparam logic [31:0] CARRY  = 32'h40800000;
`else
    localparam logic [31:0] RND_UP = 32'h3F800001;
    localparam logic [31:0] CARRY  = 32'h407FFFFF;
`endif

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Monitor: compares the head of the queue whenever a result is shown.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %h expected none",
                             out_data);
                end else begin
                    check(name_q[0], {30'b0, out_ovf, out_unf, out_data},
                          {30'b0, exp_q[0]});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(name_q.pop_front());
                    end
                end
            end
        end
    end

    // Called right after a falling edge; returns after the accepting edge.
    task automatic send(input string nm, input logic [25:0] p,
                        input logic sa, input logic sb,
                        input logic [7:0] ea, input logic [7:0] eb,
                        input logic [33:0] want);
        int n;
        n = 0;
        prod     = p;
        sign_a   = sa;
        sign_b   = sb;
        exp_a    = ea;
        exp_b    = eb;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_accept: got in_ready 0 expected 1", nm);
        end else begin
            exp_q.push_back(want);
            name_q.push_back(nm);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        prod      = '0;
        sign_a    = 1'b0;
        sign_b    = 1'b0;
        exp_a     = '0;
        exp_b     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out", {out_valid, out_ovf, out_unf, out_data}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {63'b0, in_ready}, 64'h1);
        @(negedge clk);

        send("one", ONE, 0, 0, 127, 127, {2'b00, 32'h3F800000});
        #1;
        check("latency_early", {63'b0, out_valid}, 64'h0);
        @(negedge clk);
        #1;
        check("latency_on", {63'b0, out_valid}, 64'h1);
        @(negedge clk);

        send("neg1p5x2", 26'(3) << 23, 1, 0, 127, 128, {2'b00, 32'hC0400000});
        send("tie_even", ONE | 26'd1, 0, 0, 127, 127, {2'b00, 32'h3F800000});
        send("rnd_up",   ONE | 26'd3, 0, 0, 127, 127, {2'b00, RND_UP});
        send("carry", 26'h3FFFFFF, 0, 0, 127, 127, {2'b00, CARRY});
        send("small_p", 26'd1, 0, 0, 127, 127, {2'b00, 32'h33800000});
        send("ovf", ONE, 0, 0, 200, 200, {2'b10, 32'h7F800000});
        send("unf", ONE, 1, 0, 20, 20, {2'b01, 32'h80000000});
        send("zero_exp", ONE, 1, 0, 0, 127, {2'b00, 32'h80000000});
        send("zero_prod", 26'd0, 0, 0, 127, 127, {2'b00, 32'h00000000});
        send("inf_in", ONE, 0, 1, 255, 127, {2'b00, 32'hFF800000});
        send("max_norm", ONE, 0, 0, 127, 254, {2'b00, 32'h7F000000});
        send("edge_unf", ONE, 0, 0, 1, 126, {2'b01, 32'h00000000});
        send("min_norm", ONE, 0, 0, 1, 127, {2'b00, 32'h00800000});
        drain();

        out_ready = 1'b0;
        fork
            begin
                send("bp0", ONE, 0, 0, 127, 127, {2'b00, 32'h3F800000});
                send("bp1", ONE, 0, 0, 127, 128, {2'b00, 32'h40000000});
                send("bp2", ONE, 0, 0, 127, 129, {2'b00, 32'h40800000});
                send("bp3", ONE, 0, 0, 127, 130, {2'b00, 32'h41000000});
            end
            begin
                repeat (2) @(negedge clk);
                #1;
                check("bp_ready_drop", {63'b0, in_ready}, 64'h0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send("dropped_a", ONE, 0, 0, 127, 127, {2'b00, 32'h3F800000});
        send("dropped_b", ONE, 0, 0, 127, 128, {2'b00, 32'h40000000});
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'h0);
        exp_q.delete();
        name_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("rst_in_ready", {63'b0, in_ready}, 64'h1);
        @(negedge clk);
        send("post_rst", 26'(3) << 23, 0, 0, 127, 127, {2'b00, 32'h3FC00000});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
